reg_bank_dual: RTL and testbench
================================

REG_BANK_DUAL -- requirements
Module: reg_bank_dual

Interface
REQ-001 Parameter WIDTH, default 16, register/data bus width in bits.
REQ-002 Parameter DEPTH, default 4, number of registers in the bank (2..16).
REQ-003 Parameter AW, default 2, select-field width; SHALL satisfy 2^AW >= DEPTH.
REQ-004 One clock; reset is synchronous and active-high (ports clk and rst).
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 bus_wr  in  1  write bus_din into register bus_wsel.
REQ-008 bus_wsel  in  AW  bus write select.
REQ-009 bus_din  in  WIDTH  bus write data.
REQ-010 bus_rd  in  1  drive bus_dout; else bus_dout is high-Z.
REQ-011 bus_rsel  in  AW  bus read select.
REQ-012 bus_dout  out  WIDTH  tri-state read data.
REQ-013 inc  in  1  increment register inc_sel by 1.
REQ-014 inc_sel  in  AW  increment select.
REQ-015 inc_wrap  out  1  one-cycle pulse: last increment wrapped all-ones to 0.
REQ-016 mem_ld / mem_st  in  1 each  start memory load / store transfer.
REQ-017 mem_sel  in  AW  register for the transfer, sampled at start.
REQ-018 mem_din  in  WIDTH  load data from memory.
REQ-019 mem_dout  out  WIDTH  tri-state store data.
REQ-020 mem_ack  in  1  memory completes current transfer this cycle.
REQ-021 mem_busy  out  1  transfer in progress.

Function
REQ-022 FSM states SHALL be IDLE, LOAD_WAIT, STORE_DRIVE.
REQ-023 IDLE + mem_ld -> LOAD_WAIT; IDLE + mem_st (no mem_ld) -> STORE_DRIVE; mem_sel latched on the same edge.
REQ-024 mem_ld and mem_st together in IDLE: load SHALL win, store dropped.
REQ-025 mem_ld/mem_st outside IDLE SHALL be ignored (no queueing).
REQ-026 LOAD_WAIT + mem_ack: mem_din written to latched register on that edge, -> IDLE.
REQ-027 STORE_DRIVE: mem_dout = current value of latched register (else high-Z); mem_ack -> IDLE.
REQ-028 mem_ack in IDLE SHALL have no effect.
REQ-029 mem_busy = 1 exactly in LOAD_WAIT and STORE_DRIVE (registered state decode).
REQ-030 bus_dout = register[bus_rsel] combinationally when bus_rd; no write bypass (new value visible the cycle after the write edge).
REQ-031 Per-register update priority on one edge: bus write > load capture > increment; losers discarded, FSM still advances.
REQ-032 Different registers SHALL all update on the same edge without interference.
REQ-033 Increment modulo 2^WIDTH; inc_wrap = 1 the cycle after an applied increment from all-ones, else 0.
REQ-034 Select value >= DEPTH: writes/increments/loads ignored, reads return 0, store drives 0.

Reset
REQ-035 rst SHALL clear all registers to 0, FSM to IDLE, mem_busy and inc_wrap to 0; outputs high-Z unless bus_rd.
REQ-036 rst during a transfer SHALL abort it; mem_ack/mem_din in that cycle ignored.
REQ-037 rst SHALL take priority over all write, increment and transfer inputs.

Structure
REQ-038 Shared package reg_bank_pkg SHALL hold FSM state encoding and default WIDTH/DEPTH/AW constants.
REQ-039 Transfer FSM SHALL be sub-module mem_xfer_fsm (state, latched select, busy); register array and priority mux stay in top.

Verification
REQ-040 Reset, bus_wr sel=2 din=0xABCD, next cycle bus_rd sel=2 -> bus_dout=0xABCD; bus_rd=0 -> high-Z.
REQ-041 mem_ld sel=1, mem_ack after 3 cycles with mem_din=0x1234 -> busy high 3 cycles, reg1=0x1234 next cycle, busy 0.
REQ-042 reg0=0xFFFF, inc sel=0 -> reg0=0x0000, inc_wrap pulses exactly one cycle.
REQ-043 Same edge: bus_wr sel=3 din=0x0005, load capture sel=3 din=0x0009, inc sel=3 -> reg3=0x0005, FSM IDLE.
REQ-044 mem_st sel=0 (reg0=0x00AA), rst asserted before mem_ack -> FSM IDLE, mem_dout high-Z, reg0=0.
REQ-045 mem_ld and mem_st same cycle, then mem_st while busy -> only load performed, busy single transfer.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the dual-access register bank: transfer FSM encoding
// and default geometry.
package reg_bank_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_AW    = 2;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOAD_WAIT   = 2'd1,
    STORE_DRIVE = 2'd2
  } xfer_state_t;

endpackage

// File: rtl/mem_xfer_fsm.sv
// Memory transfer sequencer: one load or store at a time, select latched at
// start, busy flag registered alongside the state.
module mem_xfer_fsm
  import reg_bank_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_ld,
  input  logic          mem_st,
  input  logic          mem_ack,
  input  logic [AW-1:0] mem_sel,
  output logic [AW-1:0] xfer_sel,
  output logic          busy,
  output logic          capture,
  output logic          storing
);

  xfer_state_t   state_reg;
  logic [AW-1:0] sel_reg;
  logic          busy_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Load wins a simultaneous request; the store is simply dropped.
          if (mem_ld) begin
            state_reg <= LOAD_WAIT;
            sel_reg   <= mem_sel;
            busy_reg  <= 1'b1;
          end else if (mem_st) begin
            state_reg <= STORE_DRIVE;
            sel_reg   <= mem_sel;
            busy_reg  <= 1'b1;
          end
        end
        LOAD_WAIT, STORE_DRIVE: begin
          if (mem_ack) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign xfer_sel = sel_reg;
  assign busy     = busy_reg;
  assign capture  = (state_reg == LOAD_WAIT) && mem_ack;
  assign storing  = (state_reg == STORE_DRIVE);

endmodule

// File: rtl/reg_bank_dual.sv
// Register bank with a bus port, per-register increment and a memory
// load/store port; bus write > load capture > increment on each register.
module reg_bank_dual
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_wr,
  input  logic [AW-1:0]    bus_wsel,
  input  logic [WIDTH-1:0] bus_din,
  input  logic             bus_rd,
  input  logic [AW-1:0]    bus_rsel,
  output logic [WIDTH-1:0] bus_dout,
  input  logic             inc,
  input  logic [AW-1:0]    inc_sel,
  output logic             inc_wrap,
  input  logic             mem_ld,
  input  logic             mem_st,
  input  logic [AW-1:0]    mem_sel,
  input  logic [WIDTH-1:0] mem_din,
  output logic [WIDTH-1:0] mem_dout,
  input  logic             mem_ack,
  output logic             mem_busy
);

  logic [WIDTH-1:0] regs_reg [DEPTH];
  logic [DEPTH-1:0] wrap_hit;
  logic             inc_wrap_reg;
  logic [AW-1:0]    xfer_sel;
  logic             capture;
  logic             storing;
  logic [WIDTH-1:0] bus_val;
  logic [WIDTH-1:0] store_val;

  mem_xfer_fsm #(.AW(AW)) u_xfer (
    .clk      (clk),
    .rst      (rst),
    .mem_ld   (mem_ld),
    .mem_st   (mem_st),
    .mem_ack  (mem_ack),
    .mem_sel  (mem_sel),
    .xfer_sel (xfer_sel),
    .busy     (mem_busy),
    .capture  (capture),
    .storing  (storing)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    logic wr_hit;
    logic ld_hit;
    logic inc_hit;

    assign wr_hit  = bus_wr  && (bus_wsel == AW'(gi));
    assign ld_hit  = capture && (xfer_sel == AW'(gi));
    assign inc_hit = inc     && (inc_sel  == AW'(gi));
    // Only an increment that actually lands may report a wrap.
    assign wrap_hit[gi] = inc_hit && !wr_hit && !ld_hit && (&regs_reg[gi]);

    always_ff @(posedge clk) begin
      if (rst)
        regs_reg[gi] <= '0;
      else if (wr_hit)
        regs_reg[gi] <= bus_din;
      else if (ld_hit)
        regs_reg[gi] <= mem_din;
      else if (inc_hit)
        regs_reg[gi] <= regs_reg[gi] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      inc_wrap_reg <= 1'b0;
    else
      inc_wrap_reg <= |wrap_hit;
  end

  // Selects beyond the populated registers match nothing and read as zero.
  always_comb begin
    bus_val   = '0;
    store_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus_rsel == AW'(i)) bus_val   = regs_reg[i];
      if (xfer_sel == AW'(i)) store_val = regs_reg[i];
    end
  end

  assign bus_dout = bus_rd  ? bus_val   : 'z;
  assign mem_dout = storing ? store_val : 'z;
  assign inc_wrap = inc_wrap_reg;

endmodule

// File: tb/tb_reg_bank_dual.sv
// Directed bench for reg_bank_dual: a vector table for bus/increment traffic
// plus hand-written sequences for the memory transfer corner cases.
module tb_reg_bank_dual;

  localparam logic [15:0] HIZ = 16'hFFFF;  // undriven nets float to the pullup

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_wr, bus_rd, inc, mem_ld, mem_st, mem_ack;
  logic [1:0]  bus_wsel, bus_rsel, inc_sel, mem_sel;
  logic [15:0] bus_din, mem_din;
  wire  [15:0] bus_dout;
  wire  [15:0] mem_dout;
  logic        inc_wrap, mem_busy;

  int checks = 0;
  int errors = 0;

  pullup (bus_dout);
  pullup (mem_dout);

  always #5 clk = ~clk;

  reg_bank_dual dut (
    .clk(clk), .rst(rst),
    .bus_wr(bus_wr), .bus_wsel(bus_wsel), .bus_din(bus_din),
    .bus_rd(bus_rd), .bus_rsel(bus_rsel), .bus_dout(bus_dout),
    .inc(inc), .inc_sel(inc_sel), .inc_wrap(inc_wrap),
    .mem_ld(mem_ld), .mem_st(mem_st), .mem_sel(mem_sel),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_ack(mem_ack), .mem_busy(mem_busy)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  wsel;
    logic [15:0] din;
    logic        rd;
    logic [1:0]  rsel;
    logic        inc;
    logic [1:0]  isel;
    logic [15:0] exp_dout;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%04h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_wr = 0; bus_wsel = 0; bus_din = 0; bus_rd = 0; bus_rsel = 0;
    inc = 0; inc_sel = 0; mem_ld = 0; mem_st = 0; mem_sel = 0;
    mem_din = 0; mem_ack = 0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] sel, input logic [15:0] exp);
    bus_rd = 1; bus_rsel = sel;
    #1;
    check(name, bus_dout, exp);
    bus_rd = 0;
  endtask

  task automatic bus_write(input logic [1:0] sel, input logic [15:0] val);
    bus_wr = 1; bus_wsel = sel; bus_din = val;
    tick();
    bus_wr = 0;
  endtask

  initial begin
    //             wr wsel din       rd rsel inc isel exp_dout  wrap
    vecs[0]  = '{1, 2, 16'hABCD, 1, 2, 0, 0, 16'hABCD, 0};
    vecs[1]  = '{0, 0, 16'h0000, 0, 2, 0, 0, HIZ,      0};
    vecs[2]  = '{1, 0, 16'hFFFF, 1, 0, 0, 0, 16'hFFFF, 0};
    vecs[3]  = '{0, 0, 16'h0000, 1, 0, 1, 0, 16'h0000, 1};
    vecs[4]  = '{0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0};
    vecs[5]  = '{0, 0, 16'h0000, 1, 1, 1, 1, 16'h0001, 0};
    vecs[6]  = '{1, 1, 16'h0010, 1, 1, 1, 1, 16'h0010, 0};
    vecs[7]  = '{1, 3, 16'h7777, 1, 2, 1, 2, 16'hABCE, 0};
    vecs[8]  = '{0, 0, 16'h0000, 1, 3, 0, 0, 16'h7777, 0};
    vecs[9]  = '{1, 0, 16'hFFFF, 1, 0, 0, 0, 16'hFFFF, 0};
    vecs[10] = '{1, 0, 16'h0042, 1, 0, 1, 0, 16'h0042, 0};

    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    check("rst_busy", {15'd0, mem_busy}, 16'h0000);
    check("rst_wrap", {15'd0, inc_wrap}, 16'h0000);
    check("rst_bus_hiz", bus_dout, HIZ);
    check("rst_mem_hiz", mem_dout, HIZ);
    for (int k = 0; k < 4; k++) rd_check($sformatf("rst_reg%0d", k), 2'(k), 16'h0000);

    for (int i = 0; i < 11; i++) begin
      bus_wr = vecs[i].wr; bus_wsel = vecs[i].wsel; bus_din = vecs[i].din;
      bus_rd = vecs[i].rd; bus_rsel = vecs[i].rsel;
      inc = vecs[i].inc; inc_sel = vecs[i].isel;
      tick();
      check($sformatf("vec%0d_dout", i), bus_dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_wrap", i), {15'd0, inc_wrap}, {15'd0, vecs[i].exp_wrap});
    end
    idle_inputs();

    // New write data only becomes visible after the write edge.
    bus_wr = 1; bus_wsel = 1; bus_din = 16'h5A5A; bus_rd = 1; bus_rsel = 1;
    #1;
    check("no_bypass_before", bus_dout, 16'h0010);
    tick();
    check("no_bypass_after", bus_dout, 16'h5A5A);
    idle_inputs();

    // Load into reg1, ack in the third busy cycle.
    mem_ld = 1; mem_sel = 1;
    tick();
    mem_ld = 0; mem_sel = 0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ld_busy_c%0d", k), {15'd0, mem_busy}, 16'h0001);
      check($sformatf("ld_memdout_hiz_c%0d", k), mem_dout, HIZ);
      if (k == 2) begin
        mem_ack = 1; mem_din = 16'h1234;
      end
      tick();
    end
    mem_ack = 0; mem_din = 0;
    check("ld_busy_done", {15'd0, mem_busy}, 16'h0000);
    rd_check("ld_reg1", 1, 16'h1234);

    // Write, load capture and increment collide on reg3: the write wins.
    mem_ld = 1; mem_sel = 3;
    tick();
    mem_ld = 0;
    mem_ack = 1; mem_din = 16'h0009;
    bus_wr = 1; bus_wsel = 3; bus_din = 16'h0005;
    inc = 1; inc_sel = 3;
    tick();
    idle_inputs();
    rd_check("prio_reg3", 3, 16'h0005);
    check("prio_busy", {15'd0, mem_busy}, 16'h0000);

    // Three different registers updated on one edge by three sources.
    mem_ld = 1; mem_sel = 2;
    tick();
    mem_ld = 0;
    mem_ack = 1; mem_din = 16'h0BEE;
    bus_wr = 1; bus_wsel = 0; bus_din = 16'h0100;
    inc = 1; inc_sel = 1;
    tick();
    idle_inputs();
    rd_check("par_reg2", 2, 16'h0BEE);
    rd_check("par_reg0", 0, 16'h0100);
    rd_check("par_reg1", 1, 16'h1235);

    // Store from reg0 aborted by reset before the ack.
    bus_write(0, 16'h00AA);
    mem_st = 1; mem_sel = 0;
    tick();
    mem_st = 0;
    check("st_busy", {15'd0, mem_busy}, 16'h0001);
    check("st_mem_dout", mem_dout, 16'h00AA);
    rst = 1; mem_ack = 1; mem_din = 16'h7E7E;
    tick();
    rst = 0; mem_ack = 0;
    check("abort_busy", {15'd0, mem_busy}, 16'h0000);
    check("abort_mem_hiz", mem_dout, HIZ);
    rd_check("abort_reg0", 0, 16'h0000);

    // Simultaneous load/store: load wins; store while busy is not queued.
    bus_write(1, 16'h1111);
    bus_write(2, 16'h2222);
    mem_ld = 1; mem_st = 1; mem_sel = 1;
    tick();
    mem_ld = 0; mem_sel = 2;
    check("both_busy", {15'd0, mem_busy}, 16'h0001);
    check("both_mem_hiz", mem_dout, HIZ);
    tick();
    mem_st = 0;
    check("st_ignored_busy", {15'd0, mem_busy}, 16'h0001);
    check("st_ignored_hiz", mem_dout, HIZ);
    mem_ack = 1; mem_din = 16'hCAFE;
    tick();
    mem_ack = 0; mem_din = 0;
    check("both_done_busy", {15'd0, mem_busy}, 16'h0000);
    rd_check("both_reg1", 1, 16'hCAFE);
    rd_check("both_reg2", 2, 16'h2222);
    tick();
    check("no_queue_busy", {15'd0, mem_busy}, 16'h0000);
    check("no_queue_hiz", mem_dout, HIZ);

    // A stray ack in IDLE must not write anything.
    mem_ack = 1; mem_din = 16'hDEAD;
    tick();
    idle_inputs();
    check("idle_ack_busy", {15'd0, mem_busy}, 16'h0000);
    rd_check("idle_ack_reg1", 1, 16'hCAFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
